// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder controller. A single full adder is reused over WIDTH clock
// cycles, LSB first, to form {cout, sum} = a + b + cin. Operands come in on a
// valid/ready handshake. The result is held on a second valid/ready handshake
// until the consumer takes it. This trades latency for area compared to a
// WIDTH-bit ripple adder.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      a, b, cin are valid this cycle
//   in_ready   out  1      controller is idle and can take operands
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in
//   out_valid  out  1      sum/cout hold a finished result
//   out_ready  in   1      consumer accepts the result
//   sum        out  WIDTH  (a + b + cin) mod 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1
//   busy       out  1      bits are being processed
// ---------------------------------------------------------------------------

// One-bit full adder. It is the only arithmetic element in the controller.
module fullAdder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Plain combinational full adder.
    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_sh_q, res_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               fa_sum;
    logic               fa_cout;

    // The adder always sees the current LSBs of the operand shifters and the
    // running carry. Its outputs only matter while in RUN.
    fullAdder u_fa (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Handshake and status outputs are pure decodes of the state. This keeps
    // in_ready and out_valid mutually exclusive by construction.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign sum       = sum_q;
    assign cout      = cout_q;

    // Next-state and datapath logic. Each register holds its value by default.
    // While in RUN, every cycle consumes one operand bit pair. The new sum bit
    // is shifted in at the MSB, so after WIDTH cycles bit 0 of the result ends
    // up at bit 0. On the last cycle the fully shifted value is copied straight
    // into sum, so the result and out_valid appear on the same edge.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    carry_d  = cin;
                    cnt_d    = '0;
                    res_sh_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = (res_sh_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    sum_d   = res_sh_d;
                    cout_d  = fa_cout;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. An asynchronous reset abandons any
    // operation in flight and clears the visible result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Three controllers with WIDTH = 1, 8 and 16 share one clock and one reset.
// Index 1 (WIDTH = 8) runs the directed scenarios. After that, all three
// widths get a random sweep. Every result is compared against a + b + cin
// computed with ordinary arithmetic. The latency from the accepting edge to
// out_valid is also measured.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

    logic clk;
    logic rst_n;

    logic [2:0]        inValid;
    logic [2:0][15:0]  aIn;
    logic [2:0][15:0]  bIn;
    logic [2:0]        cinIn;
    logic [2:0]        outReady;

    logic [2:0]        inReady;
    logic [2:0]        outValid;
    logic [2:0]        coutOut;
    logic [2:0]        busyOut;
    logic [2:0][15:0]  sumOut;

    logic [0:0]        sum1;
    logic [7:0]        sum8;
    logic [15:0]       sum16;

    int numCompared;
    int numMismatched;

    int widthOf [3] = '{1, 8, 16};

    assign sumOut[0] = 16'(sum1);
    assign sumOut[1] = 16'(sum8);
    assign sumOut[2] = sum16;

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid[0]), .in_ready(inReady[0]),
        .a(aIn[0][0:0]), .b(bIn[0][0:0]), .cin(cinIn[0]),
        .out_valid(outValid[0]), .out_ready(outReady[0]),
        .sum(sum1), .cout(coutOut[0]), .busy(busyOut[0])
    );

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid[1]), .in_ready(inReady[1]),
        .a(aIn[1][7:0]), .b(bIn[1][7:0]), .cin(cinIn[1]),
        .out_valid(outValid[1]), .out_ready(outReady[1]),
        .sum(sum8), .cout(coutOut[1]), .busy(busyOut[1])
    );

    serial_add_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid[2]), .in_ready(inReady[2]),
        .a(aIn[2]), .b(bIn[2]), .cin(cinIn[2]),
        .out_valid(outValid[2]), .out_ready(outReady[2]),
        .sum(sum16), .cout(coutOut[2]), .busy(busyOut[2])
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        numCompared++;
        if (got !== exp) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one complete operation on instance k. The task waits gap idle
    // cycles, offers the operands, and measures the cycles until out_valid.
    // It then checks the result against plain arithmetic, holds off the
    // consumer for hold cycles, and finally hands the result off. When junk
    // is set, extra in_valid pulses with a=0x11 are driven while the
    // operation is in flight; these must be ignored.
    task automatic applyStimulus(input int k, input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input int gap, input int hold, input bit junk);
        int          w;
        int          cycles;
        logic [16:0] mask;
        logic [16:0] exp;
        logic [15:0] expSum;
        logic        expCout;

        w       = widthOf[k];
        mask    = (17'd1 << w) - 17'd1;
        exp     = (17'(a) & mask) + (17'(b) & mask) + 17'(c);
        expSum  = 16'(exp & mask);
        expCout = exp[w];

        repeat (gap) @(negedge clk);
        checkOutput($sformatf("w%0d in_ready idle", w), 64'(inReady[k]), 64'd1);
        inValid[k] = 1'b1;
        aIn[k]     = a;
        bIn[k]     = b;
        cinIn[k]   = c;
        @(negedge clk);
        inValid[k] = 1'b0;
        cycles     = 0;
        checkOutput($sformatf("w%0d busy after accept", w), 64'(busyOut[k]), 64'd1);
        checkOutput($sformatf("w%0d in_ready in run", w), 64'(inReady[k]), 64'd0);

        while (!outValid[k] && cycles < 200) begin
            if (junk) begin
                inValid[k] = 1'($urandom_range(0, 1));
                aIn[k]     = 16'h0011;
                bIn[k]     = 16'($urandom);
                cinIn[k]   = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cycles++;
        end
        inValid[k] = 1'b0;

        checkOutput($sformatf("w%0d latency", w), 64'(cycles), 64'(w));
        checkOutput($sformatf("w%0d sum", w), 64'(sumOut[k]), 64'(expSum));
        checkOutput($sformatf("w%0d cout", w), 64'(coutOut[k]), 64'(expCout));

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput($sformatf("w%0d hold out_valid", w), 64'(outValid[k]), 64'd1);
            checkOutput($sformatf("w%0d hold in_ready", w), 64'(inReady[k]), 64'd0);
            checkOutput($sformatf("w%0d hold sum", w), 64'(sumOut[k]), 64'(expSum));
            checkOutput($sformatf("w%0d hold cout", w), 64'(coutOut[k]), 64'(expCout));
        end

        outReady[k] = 1'b1;
        @(negedge clk);
        outReady[k] = 1'b0;
        checkOutput($sformatf("w%0d out_valid after handoff", w), 64'(outValid[k]), 64'd0);
        checkOutput($sformatf("w%0d in_ready after handoff", w), 64'(inReady[k]), 64'd1);
        checkOutput($sformatf("w%0d sum retained", w), 64'(sumOut[k]), 64'(expSum));
        checkOutput($sformatf("w%0d cout retained", w), 64'(coutOut[k]), 64'(expCout));
    endtask

    // Main sequence: reset checks, the directed scenarios on the 8-bit
    // instance, then random sweeps on all three widths.
    initial begin
        numCompared   = 0;
        numMismatched = 0;
        rst_n    = 1'b0;
        inValid  = '0;
        aIn      = '0;
        bIn      = '0;
        cinIn    = '0;
        outReady = '0;

        #3;
        for (int k = 0; k < 3; k++) begin
            checkOutput("reset sum", 64'(sumOut[k]), 64'd0);
            checkOutput("reset cout", 64'(coutOut[k]), 64'd0);
            checkOutput("reset out_valid", 64'(outValid[k]), 64'd0);
            checkOutput("reset busy", 64'(busyOut[k]), 64'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput("post-reset in_ready", 64'(inReady[k]), 64'd1);
        end

        $display("[TB] directed cases, WIDTH=8");
        applyStimulus(1, 16'h005A, 16'h003C, 1'b0, 0, 0, 1'b0);
        applyStimulus(1, 16'h00FF, 16'h0001, 1'b0, 1, 0, 1'b0);
        applyStimulus(1, 16'h00FF, 16'h0000, 1'b1, 1, 0, 1'b0);
        applyStimulus(1, 16'h0012, 16'h0034, 1'b1, 0, 5, 1'b0);
        applyStimulus(1, 16'h0077, 16'h0009, 1'b0, 0, 2, 1'b1);
        repeat (4) begin
            @(negedge clk);
            checkOutput("no second result", 64'(outValid[1]), 64'd0);
        end

        // Reset in the middle of an operation. The previous result (0x80) is
        // still visible on sum, so the clear is observable.
        inValid[1] = 1'b1;
        aIn[1]     = 16'h0033;
        bIn[1]     = 16'h0044;
        cinIn[1]   = 1'b0;
        @(negedge clk);
        inValid[1] = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("busy before reset", 64'(busyOut[1]), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid-run reset sum", 64'(sumOut[1]), 64'd0);
        checkOutput("mid-run reset cout", 64'(coutOut[1]), 64'd0);
        checkOutput("mid-run reset busy", 64'(busyOut[1]), 64'd0);
        checkOutput("mid-run reset out_valid", 64'(outValid[1]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 16'h0080, 16'h0080, 1'b0, 1, 0, 1'b0);

        for (int k = 0; k < 3; k++) begin
            $display("[TB] random sweep, WIDTH=%0d", widthOf[k]);
            for (int n = 0; n < 400; n++) begin
                applyStimulus(k, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                              $urandom_range(0, 3), $urandom_range(0, 3),
                              1'($urandom_range(0, 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
